// File: rtl/memory_arbiter.sv
// Two-to-one arbiter between the instruction and data memory ports and the single shared memory bus.
// Keeps one transaction outstanding, buffers requests that lose arbitration and routes each response back to its owner.
module memory_arbiter (
   input  logic        reset,
   input  logic        clock,
   input  logic        imemory_valid,
   input  logic        imemory_instr,
   input  logic [31:0] imemory_addr,
   input  logic [31:0] imemory_wdata,
   input  logic [3:0]  imemory_wstrb,
   output logic [31:0] imemory_rdata,
   output logic        imemory_error,
   output logic        imemory_ready,
   input  logic        dmemory_valid,
   input  logic        dmemory_instr,
   input  logic [31:0] dmemory_addr,
   input  logic [31:0] dmemory_wdata,
   input  logic [3:0]  dmemory_wstrb,
   output logic [31:0] dmemory_rdata,
   output logic        dmemory_error,
   output logic        dmemory_ready,
   output logic        memory_valid,
   output logic        memory_instr,
   output logic [31:0] memory_addr,
   output logic [31:0] memory_wdata,
   output logic [3:0]  memory_wstrb,
   input  logic [31:0] memory_rdata,
   input  logic        memory_error,
   input  logic        memory_ready
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   typedef enum logic [2:0] {SEL_NONE, SEL_PEND_D, SEL_NEW_D, SEL_PEND_I, SEL_NEW_I} sel_t;

   state_t state, state_next;
   sel_t   sel;
   logic   can_issue;

   logic              pend_i, pend_i_next;
   logic              pend_i_instr, pend_i_instr_next;
   logic [ADDR_W-1:0] pend_i_addr, pend_i_addr_next;
   logic [DATA_W-1:0] pend_i_wdata, pend_i_wdata_next;
   logic [STRB_W-1:0] pend_i_wstrb, pend_i_wstrb_next;

   logic              pend_d, pend_d_next;
   logic              pend_d_instr, pend_d_instr_next;
   logic [ADDR_W-1:0] pend_d_addr, pend_d_addr_next;
   logic [DATA_W-1:0] pend_d_wdata, pend_d_wdata_next;
   logic [STRB_W-1:0] pend_d_wstrb, pend_d_wstrb_next;

   // The bus can accept a new request when idle or in the cycle the current one completes.
   assign can_issue = reset && ((state == IDLE) || memory_ready);

   // Fixed priority: data always wins over instruction, buffered before new.
   always_comb begin
      sel = SEL_NONE;
      if (can_issue) begin
         if (pend_d)             sel = SEL_PEND_D;
         else if (dmemory_valid) sel = SEL_NEW_D;
         else if (pend_i)        sel = SEL_PEND_I;
         else if (imemory_valid) sel = SEL_NEW_I;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         pend_i       <= 1'b0;
         pend_i_instr <= 1'b0;
         pend_i_addr  <= '0;
         pend_i_wdata <= '0;
         pend_i_wstrb <= '0;
         pend_d       <= 1'b0;
         pend_d_instr <= 1'b0;
         pend_d_addr  <= '0;
         pend_d_wdata <= '0;
         pend_d_wstrb <= '0;
      end else begin
         state        <= state_next;
         pend_i       <= pend_i_next;
         pend_i_instr <= pend_i_instr_next;
         pend_i_addr  <= pend_i_addr_next;
         pend_i_wdata <= pend_i_wdata_next;
         pend_i_wstrb <= pend_i_wstrb_next;
         pend_d       <= pend_d_next;
         pend_d_instr <= pend_d_instr_next;
         pend_d_addr  <= pend_d_addr_next;
         pend_d_wdata <= pend_d_wdata_next;
         pend_d_wstrb <= pend_d_wstrb_next;
      end
   end

   always_comb begin
      state_next        = state;
      pend_i_next       = pend_i;
      pend_i_instr_next = pend_i_instr;
      pend_i_addr_next  = pend_i_addr;
      pend_i_wdata_next = pend_i_wdata;
      pend_i_wstrb_next = pend_i_wstrb;
      pend_d_next       = pend_d;
      pend_d_instr_next = pend_d_instr;
      pend_d_addr_next  = pend_d_addr;
      pend_d_wdata_next = pend_d_wdata;
      pend_d_wstrb_next = pend_d_wstrb;
      memory_valid      = 1'b0;
      memory_instr      = 1'b0;
      memory_addr       = '0;
      memory_wdata      = '0;
      memory_wstrb      = '0;
      imemory_rdata     = '0;
      imemory_error     = 1'b0;
      imemory_ready     = 1'b0;
      dmemory_rdata     = '0;
      dmemory_error     = 1'b0;
      dmemory_ready     = 1'b0;

      if (reset) begin
         // Response goes only to the port that owns the in-flight transaction.
         if (state == BUSY_I) begin
            imemory_rdata = memory_rdata;
            imemory_error = memory_error;
            imemory_ready = memory_ready;
         end else if (state == BUSY_D) begin
            dmemory_rdata = memory_rdata;
            dmemory_error = memory_error;
            dmemory_ready = memory_ready;
         end

         if (can_issue) state_next = IDLE;

         case (sel)
            SEL_PEND_D: begin
               memory_valid = 1'b1;
               memory_instr = pend_d_instr;
               memory_addr  = pend_d_addr;
               memory_wdata = pend_d_wdata;
               memory_wstrb = pend_d_wstrb;
               pend_d_next  = 1'b0;
               state_next   = BUSY_D;
            end
            SEL_NEW_D: begin
               memory_valid = 1'b1;
               memory_instr = dmemory_instr;
               memory_addr  = dmemory_addr;
               memory_wdata = dmemory_wdata;
               memory_wstrb = dmemory_wstrb;
               state_next   = BUSY_D;
            end
            SEL_PEND_I: begin
               memory_valid = 1'b1;
               memory_instr = pend_i_instr;
               memory_addr  = pend_i_addr;
               memory_wdata = pend_i_wdata;
               memory_wstrb = pend_i_wstrb;
               pend_i_next  = 1'b0;
               state_next   = BUSY_I;
            end
            SEL_NEW_I: begin
               memory_valid = 1'b1;
               memory_instr = imemory_instr;
               memory_addr  = imemory_addr;
               memory_wdata = imemory_wdata;
               memory_wstrb = imemory_wstrb;
               state_next   = BUSY_I;
            end
            default: ;
         endcase

         // A request pulse that was not sent straight through is held until the bus frees up.
         if (imemory_valid && (sel != SEL_NEW_I)) begin
            pend_i_next       = 1'b1;
            pend_i_instr_next = imemory_instr;
            pend_i_addr_next  = imemory_addr;
            pend_i_wdata_next = imemory_wdata;
            pend_i_wstrb_next = imemory_wstrb;
         end
         if (dmemory_valid && (sel != SEL_NEW_D)) begin
            pend_d_next       = 1'b1;
            pend_d_instr_next = dmemory_instr;
            pend_d_addr_next  = dmemory_addr;
            pend_d_wdata_next = dmemory_wdata;
            pend_d_wstrb_next = dmemory_wstrb;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then randomized traffic, all checked against a
// transaction-level reference model of owner, pending requests and fixed data-first priority.
module tb_memory_arbiter;

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   logic        reset, clock;
   logic        imemory_valid, imemory_instr;
   logic [31:0] imemory_addr, imemory_wdata;
   logic [3:0]  imemory_wstrb;
   logic [31:0] imemory_rdata;
   logic        imemory_error, imemory_ready;
   logic        dmemory_valid, dmemory_instr;
   logic [31:0] dmemory_addr, dmemory_wdata;
   logic [3:0]  dmemory_wstrb;
   logic [31:0] dmemory_rdata;
   logic        dmemory_error, dmemory_ready;
   logic        memory_valid, memory_instr;
   logic [31:0] memory_addr, memory_wdata;
   logic [3:0]  memory_wstrb;
   logic [31:0] memory_rdata;
   logic        memory_error, memory_ready;

   memory_arbiter dut (
      .reset(reset), .clock(clock),
      .imemory_valid(imemory_valid), .imemory_instr(imemory_instr), .imemory_addr(imemory_addr),
      .imemory_wdata(imemory_wdata), .imemory_wstrb(imemory_wstrb), .imemory_rdata(imemory_rdata),
      .imemory_error(imemory_error), .imemory_ready(imemory_ready),
      .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr), .dmemory_addr(dmemory_addr),
      .dmemory_wdata(dmemory_wdata), .dmemory_wstrb(dmemory_wstrb), .dmemory_rdata(dmemory_rdata),
      .dmemory_error(dmemory_error), .dmemory_ready(dmemory_ready),
      .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
      .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
      .memory_error(memory_error), .memory_ready(memory_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Reference model: who owns the bus (0 none, 1 I, 2 D) and each port's held request.
   int   m_owner = 0;
   bit   m_pi = 0, m_pd = 0;
   req_t m_ri, m_rd;
   bit   m_can;
   bit   p_valid;
   int   p_who;
   bit   p_pend;
   req_t p_req;
   bit   i_out = 0, d_out = 0;

   logic        e_mv, e_minstr;
   logic [31:0] e_maddr, e_mwdata;
   logic [3:0]  e_mwstrb;
   logic [31:0] e_ird, e_drd;
   logic        e_ierr, e_irdy, e_derr, e_drdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pick(input int who, input bit pend, input req_t r);
      p_valid = 1; p_who = who; p_pend = pend; p_req = r;
   endtask

   task automatic model_eval();
      req_t ni, nd;
      ni = '{imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
      nd = '{dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
      {e_mv, e_minstr, e_maddr, e_mwdata, e_mwstrb} = '0;
      {e_ird, e_ierr, e_irdy, e_drd, e_derr, e_drdy} = '0;
      p_valid = 0; p_who = 0; p_pend = 0; p_req = '0; m_can = 0;
      if (reset === 1'b1) begin
         if (m_owner == 1) {e_ird, e_ierr, e_irdy} = {memory_rdata, memory_error, memory_ready};
         if (m_owner == 2) {e_drd, e_derr, e_drdy} = {memory_rdata, memory_error, memory_ready};
         m_can = (m_owner == 0) || memory_ready;
         if (m_can) begin
            if (m_pd)               pick(2, 1, m_rd);
            else if (dmemory_valid) pick(2, 0, nd);
            else if (m_pi)          pick(1, 1, m_ri);
            else if (imemory_valid) pick(1, 0, ni);
         end
         if (p_valid) begin
            e_mv = 1'b1;
            {e_minstr, e_maddr, e_mwdata, e_mwstrb} = p_req;
         end
      end
   endtask

   task automatic model_update();
      if (reset !== 1'b1) begin
         m_owner = 0; m_pi = 0; m_pd = 0; i_out = 0; d_out = 0;
      end else begin
         if (e_irdy) i_out = 0;
         if (e_drdy) d_out = 0;
         if (p_valid && p_pend && p_who == 1) m_pi = 0;
         if (p_valid && p_pend && p_who == 2) m_pd = 0;
         if (imemory_valid && !(p_valid && p_who == 1 && !p_pend)) begin
            m_pi = 1; m_ri = '{imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
         end
         if (dmemory_valid && !(p_valid && p_who == 2 && !p_pend)) begin
            m_pd = 1; m_rd = '{dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
         end
         if (p_valid) m_owner = p_who;
         else if (m_can) m_owner = 0;
      end
   endtask

   task automatic compare_all();
      chk("memory_valid", 32'(memory_valid), 32'(e_mv));
      chk("memory_instr", 32'(memory_instr), 32'(e_minstr));
      chk("memory_addr", memory_addr, e_maddr);
      chk("memory_wdata", memory_wdata, e_mwdata);
      chk("memory_wstrb", 32'(memory_wstrb), 32'(e_mwstrb));
      chk("imemory_rdata", imemory_rdata, e_ird);
      chk("imemory_error", 32'(imemory_error), 32'(e_ierr));
      chk("imemory_ready", 32'(imemory_ready), 32'(e_irdy));
      chk("dmemory_rdata", dmemory_rdata, e_drd);
      chk("dmemory_error", 32'(dmemory_error), 32'(e_derr));
      chk("dmemory_ready", 32'(dmemory_ready), 32'(e_drdy));
   endtask

   task automatic clear_inputs();
      reset = 1'b1;
      imemory_valid = 0; imemory_instr = 0; imemory_addr = '0; imemory_wdata = '0; imemory_wstrb = '0;
      dmemory_valid = 0; dmemory_instr = 0; dmemory_addr = '0; dmemory_wdata = '0; dmemory_wstrb = '0;
      memory_rdata = '0; memory_error = 0; memory_ready = 0;
   endtask

   task automatic tick();
      #1;
      model_eval();
      compare_all();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic ireq(input logic [31:0] a);
      imemory_valid = 1; imemory_instr = 1; imemory_addr = a;
   endtask

   task automatic dreq(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
      dmemory_valid = 1; dmemory_instr = 0; dmemory_addr = a; dmemory_wdata = w; dmemory_wstrb = s;
   endtask

   task automatic mresp(input logic [31:0] r, input logic e);
      memory_ready = 1; memory_rdata = r; memory_error = e;
   endtask

   initial begin
      // Reset held with both ports pulsing: everything stays quiet.
      for (int k = 0; k < 3; k++) begin
         clear_inputs(); reset = 0; ireq(32'h4); dreq(32'h8, 32'h1, 4'hF); mresp(32'hFFFF_FFFF, 1);
         #1;
         chk("rst_memory_valid", 32'(memory_valid), 32'h0);
         chk("rst_ready", 32'({imemory_ready, dmemory_ready}), 32'h0);
         tick();
      end
      clear_inputs(); ireq(32'h0); #1;
      chk("first_fetch_valid", 32'(memory_valid), 32'h1);
      chk("first_fetch_addr", memory_addr, 32'h0);
      tick();
      clear_inputs(); mresp(32'h1, 0); tick();

      // Single fetch with a two-cycle memory latency.
      clear_inputs(); ireq(32'h100); #1;
      chk("fetch_addr", memory_addr, 32'h100);
      chk("fetch_instr", 32'(memory_instr), 32'h1);
      tick();
      clear_inputs(); tick();
      clear_inputs(); mresp(32'h0000_0013, 0); #1;
      chk("fetch_iready", 32'(imemory_ready), 32'h1);
      chk("fetch_irdata", imemory_rdata, 32'h13);
      chk("fetch_dready", 32'(dmemory_ready), 32'h0);
      tick();

      // Collision: data store wins, fetch follows on the data response.
      clear_inputs(); ireq(32'h200); dreq(32'h8000_0000, 32'hDEAD_BEEF, 4'hF); #1;
      chk("coll_addr", memory_addr, 32'h8000_0000);
      chk("coll_wdata", memory_wdata, 32'hDEAD_BEEF);
      chk("coll_wstrb", 32'(memory_wstrb), 32'hF);
      tick();
      clear_inputs(); tick();
      clear_inputs(); mresp(32'h0, 0); #1;
      chk("coll_dready", 32'(dmemory_ready), 32'h1);
      chk("coll_iready_d", 32'(imemory_ready), 32'h0);
      chk("coll_i_issue", memory_addr, 32'h200);
      tick();
      clear_inputs(); mresp(32'h0000_0097, 0); #1;
      chk("coll_iready", 32'(imemory_ready), 32'h1);
      chk("coll_dready_i", 32'(dmemory_ready), 32'h0);
      tick();

      // Data request arriving mid-fetch is held and then issued intact.
      clear_inputs(); ireq(32'h300); tick();
      clear_inputs(); dreq(32'h40, 32'h1234, 4'h3); #1;
      chk("busy_no_issue", 32'(memory_valid), 32'h0);
      tick();
      clear_inputs(); mresp(32'h5, 0); #1;
      chk("held_addr", memory_addr, 32'h40);
      chk("held_wdata", memory_wdata, 32'h1234);
      chk("held_wstrb", 32'(memory_wstrb), 32'h3);
      tick();
      clear_inputs(); mresp(32'h55, 0); tick();

      // Error response on a data read.
      clear_inputs(); dreq(32'h10, 32'h0, 4'h0); tick();
      clear_inputs(); mresp(32'h0, 1); #1;
      chk("err_derror", 32'(dmemory_error), 32'h1);
      chk("err_dready", 32'(dmemory_ready), 32'h1);
      chk("err_drdata", dmemory_rdata, 32'h0);
      tick();
      clear_inputs(); mresp(32'h77, 0); #1;
      chk("idle_ready_ignored", 32'(dmemory_ready), 32'h0);
      tick();

      // Reset while data in flight and fetch pending.
      clear_inputs(); ireq(32'h500); dreq(32'h600, 32'h0, 4'h0); tick();
      clear_inputs(); reset = 0; tick();
      clear_inputs(); mresp(32'h9, 0); #1;
      chk("late_ready_i", 32'(imemory_ready), 32'h0);
      chk("late_ready_d", 32'(dmemory_ready), 32'h0);
      chk("late_no_issue", 32'(memory_valid), 32'h0);
      tick();

      // Randomized protocol-legal traffic.
      for (int n = 0; n < 3000; n++) begin
         clear_inputs();
         reset = ($urandom_range(0, 199) != 0);
         if (!i_out && $urandom_range(0, 3) == 0) begin
            imemory_valid = 1; imemory_instr = 1'($urandom); imemory_addr = $urandom;
            imemory_wdata = $urandom; imemory_wstrb = 4'($urandom); i_out = 1;
         end
         if (!d_out && $urandom_range(0, 3) == 0) begin
            dmemory_valid = 1; dmemory_instr = 1'($urandom); dmemory_addr = $urandom;
            dmemory_wdata = $urandom; dmemory_wstrb = 4'($urandom); d_out = 1;
         end
         if (m_owner != 0) memory_ready = ($urandom_range(0, 2) == 0);
         else              memory_ready = ($urandom_range(0, 19) == 0);
         memory_rdata = $urandom;
         memory_error = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-to-one memory request arbiter between the CPU's instruction-fetch port (imemory) and load/store port (dmemory) and the single shared memory bus (memory) that feeds the SoC address decoder (ROM, print, CLINT, CLIC, BRAM). It serialises requests so only one transaction is outstanding on the shared bus. It buffers a request that arrives while the bus is busy, and routes each response back to the port that issued it.

## Interface
Parameters: none.

Ports:
- reset  in  1  synchronous, active-low
- clock  in  1  clock, rising edge
- imemory_valid  in  1  instruction-port request strobe (one-cycle pulse)
- imemory_instr  in  1  request is an instruction fetch
- imemory_addr  in  32  byte address
- imemory_wdata  in  32  write data
- imemory_wstrb  in  4  byte write strobes; 0 = read
- imemory_rdata  out  32  read data
- imemory_error  out  1  access fault, valid with ready
- imemory_ready  out  1  response strobe (one cycle)
- dmemory_valid/instr/addr/wdata/wstrb  in  1/1/32/32/4  data-port request, same semantics
- dmemory_rdata/error/ready  out  32/1/1  data-port response
- memory_valid/instr/addr/wdata/wstrb  out  1/1/32/32/4  shared-bus request (one-cycle pulse)
- memory_rdata/error/ready  in  32/1/1  shared-bus response

## Operation
- States: IDLE, BUSY_I (instruction transaction in flight), BUSY_D (data transaction in flight).
- Per-port pending buffer: flag plus instr, addr, wdata, wstrb. Each port has at most one request outstanding; the CPU does not issue a new request on a port before that port's ready.
- Request capture:
  - A valid pulse that is not issued in the same cycle is stored in that port's pending buffer.
  - A valid pulse that is issued in the same cycle bypasses the buffer.
- Issue selection, evaluated when IDLE or in the cycle memory_ready=1:
  - Priority: pending D > new dmemory_valid > pending I > new imemory_valid. Data always beats instruction.
  - The selected request drives memory_valid=1 and its fields for exactly one cycle.
  - State becomes BUSY_D or BUSY_I. The pending flag of the issued request is cleared.
  - If nothing is selected, state becomes IDLE.
- Response routing while BUSY_x:
  - memory_rdata, memory_error and memory_ready are copied combinationally to the owning port.
  - The other port's ready, error and rdata are 0.
- memory_ready in IDLE is ignored (not forwarded).
- memory_addr/wdata/wstrb/instr are 0 whenever memory_valid=0.
- Error responses complete the transaction exactly like normal responses. The arbiter does not retry.

## Timing
- Reset (reset=0 at a rising edge): state IDLE, both pending flags cleared.
- While reset=0, all outputs are 0: memory_valid, all *_ready, all *_error, all *_rdata.
- A reset during a transaction aborts it. A late memory_ready after reset is dropped.
- Latency:
  - Issue from IDLE is combinational: zero cycles from a port's valid to memory_valid.
  - A response reaches the owning port in the same cycle as memory_ready.
- Back-to-back: the next transaction issues in the same cycle as the previous memory_ready, so there is no bubble.
- Simultaneous imemory_valid and dmemory_valid in IDLE: D is issued and I is buffered. I issues in the cycle D's ready arrives.
- A request that arrives in the same cycle as memory_ready competes in that cycle's selection under the priority above.

## Test plan
- Reset: hold reset=0 for 3 cycles while both valids pulse → all outputs 0. After release, first imemory_valid (addr 0x0) → memory_valid=1, addr 0x0 in the same cycle.
- Single fetch: imemory_valid, addr 0x100 → memory_addr 0x100, instr=1. Memory responds 2 cycles later with rdata 0x00000013 → imemory_ready=1, imemory_rdata 0x13, dmemory_ready=0.
- Collision: imemory (0x200) and dmemory store (0x80000000, wdata 0xDEADBEEF, wstrb 0xF) in the same cycle → D issues first. I issues in D's ready cycle. Each ready is routed to its own port only.
- Arrival while busy: dmemory_valid during an I transaction → buffered. It issues in I's ready cycle with unchanged addr, wdata and wstrb.
- Error: memory_error=1 with ready on a D read → dmemory_error=1, dmemory_ready=1, rdata 0. State returns to IDLE.
- Mid-transaction reset: reset=0 while BUSY_D with I pending → after reset, memory_ready=1 produces no port ready and no pending I is issued.
